// File: rtl/slot_alloc_rr.sv
// slot_alloc_rr: circular next-fit slot allocator.
// Tracks occupancy of W slots and grants one free slot per cycle with zero latency.
// Accepts up to N_FREE frees per cycle. Keeps a free-slot count and a sticky
// protocol-error flag. The grant path reads only registered state.
module slot_alloc_rr #(
  parameter int unsigned W        = 32,
  parameter int unsigned N_FREE   = 2,
  parameter int unsigned NEXT_FIT = 1,
  localparam int unsigned LW      = $clog2(W)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  output logic [LW-1:0]          alloc_id_o,
  output logic [W-1:0]           alloc_oh_o,
  input  logic [N_FREE-1:0]      free_valid_i,
  input  logic [N_FREE*LW-1:0]   free_id_i,
  output logic [W-1:0]           occ_o,
  output logic [LW:0]            free_cnt_o,
  output logic                   err_o
);

  logic [W-1:0]  r_occ;
  logic [LW-1:0] r_ptr;
  logic [LW:0]   r_free_cnt;
  logic          r_err;

  logic [LW-1:0] w_start;
  logic [LW-1:0] w_idx;
  logic [LW-1:0] w_id;
  logic          w_found;
  logic          w_ready;
  logic [W-1:0]  w_oh;

  logic [W-1:0]  w_clr;
  logic [LW-1:0] w_fid;
  logic          w_err_free;
  logic          w_hs;
  logic          w_err_alloc;
  logic [W-1:0]  w_occ_nxt;
  logic [LW:0]   w_cnt_nxt;
  logic [LW-1:0] w_ptr_nxt;

  // Number of set bits in a slot vector, sized to hold 0..W.
  function automatic logic [LW:0] popcount(input logic [W-1:0] v);
    logic [LW:0] c;
    c = {(LW+1){1'b0}};
    for (int i = 0; i < int'(W); i++) begin
      c = c + {{LW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Circular search for the first free slot starting at the pointer (or slot 0 for first-fit).
  always_comb begin
    w_start = (NEXT_FIT != 0) ? r_ptr : {LW{1'b0}};
    w_found = 1'b0;
    w_id    = w_start;
    w_idx   = w_start;
    for (int i = 0; i < int'(W); i++) begin
      // LW-bit addition wraps modulo W because W is a power of two.
      w_idx = w_start + i[LW-1:0];
      if (!w_found && !r_occ[w_idx]) begin
        w_found = 1'b1;
        w_id    = w_idx;
      end else begin
        w_found = w_found;
      end
    end
    w_ready = ~(&r_occ);
    if (w_ready) begin
      w_oh = {{(W-1){1'b0}}, 1'b1} << w_id;
    end else begin
      w_oh = {W{1'b0}};
    end
  end

  // Decode free ports into a clear mask; bad or duplicate frees only raise the error.
  always_comb begin
    w_clr      = {W{1'b0}};
    w_err_free = 1'b0;
    w_fid      = {LW{1'b0}};
    for (int k = 0; k < int'(N_FREE); k++) begin
      w_fid = free_id_i[k*LW +: LW];
      if (free_valid_i[k]) begin
        if (!r_occ[w_fid] || w_clr[w_fid]) begin
          w_err_free = 1'b1;
        end else begin
          w_clr[w_fid] = 1'b1;
        end
      end else begin
        w_clr = w_clr;
      end
    end
  end

  // Next-state computation for occupancy, count and pointer.
  always_comb begin
    w_hs        = alloc_valid_i & w_ready;
    w_err_alloc = alloc_valid_i & ~w_ready;
    // The granted slot is currently free, so it never appears in w_clr; OR-ing last lets the allocation win.
    if (w_hs) begin
      w_occ_nxt = (r_occ & ~w_clr) | w_oh;
      w_ptr_nxt = w_id + LW'(1'b1);
    end else begin
      w_occ_nxt = r_occ & ~w_clr;
      w_ptr_nxt = r_ptr;
    end
    w_cnt_nxt = r_free_cnt - {{LW{1'b0}}, w_hs} + popcount(w_clr);
  end

  // State registers with async reset and synchronous flush taking priority over traffic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_occ      <= {W{1'b0}};
      r_ptr      <= {LW{1'b0}};
      r_free_cnt <= (LW+1)'(W);
      r_err      <= 1'b0;
    end else if (flush_i) begin
      r_occ      <= {W{1'b0}};
      r_ptr      <= {LW{1'b0}};
      r_free_cnt <= (LW+1)'(W);
      r_err      <= 1'b0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_ptr      <= w_ptr_nxt;
      r_free_cnt <= w_cnt_nxt;
      r_err      <= r_err | w_err_free | w_err_alloc;
    end
  end

  assign alloc_ready_o = w_ready;
  assign alloc_id_o    = w_id;
  assign alloc_oh_o    = w_oh;
  assign occ_o         = r_occ;
  assign free_cnt_o    = r_free_cnt;
  assign err_o         = r_err;

endmodule

// File: tb/tb_slot_alloc_rr.sv
// Directed bench for slot_alloc_rr, W=8, N_FREE=2.
// It drives a next-fit and a first-fit instance from the same inputs.
// Expected values are queued as stimulus is applied and compared once the DUT responds.
module tb_slot_alloc_rr;

  localparam int W  = 8;
  localparam int LW = 3;

  localparam int S_RDY  = 0;
  localparam int S_ID   = 1;
  localparam int S_OH   = 2;
  localparam int S_OCC  = 3;
  localparam int S_CNT  = 4;
  localparam int S_ERR  = 5;
  localparam int S_FID  = 6;
  localparam int S_FOCC = 7;

  typedef struct {
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          alloc_valid_i;
  logic [1:0]    free_valid_i;
  logic [5:0]    free_id_i;

  logic          rdy, rdy_f;
  logic [LW-1:0] id, id_f;
  logic [W-1:0]  oh, oh_f;
  logic [W-1:0]  occ, occ_f;
  logic [LW:0]   cnt, cnt_f;
  logic          err, err_f;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  slot_alloc_rr #(.W(W), .N_FREE(2), .NEXT_FIT(1)) u_nf (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(rdy), .alloc_id_o(id),
    .alloc_oh_o(oh), .free_valid_i(free_valid_i), .free_id_i(free_id_i),
    .occ_o(occ), .free_cnt_o(cnt), .err_o(err)
  );

  slot_alloc_rr #(.W(W), .N_FREE(2), .NEXT_FIT(0)) u_ff (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(rdy_f), .alloc_id_o(id_f),
    .alloc_oh_o(oh_f), .free_valid_i(free_valid_i), .free_id_i(free_id_i),
    .occ_o(occ_f), .free_cnt_o(cnt_f), .err_o(err_f)
  );

  always #5 clk_i = ~clk_i;

  function automatic string nm(input int s);
    case (s)
      S_RDY:   return "ready";
      S_ID:    return "id";
      S_OH:    return "onehot";
      S_OCC:   return "occ";
      S_CNT:   return "free_cnt";
      S_ERR:   return "err";
      S_FID:   return "ff_id";
      S_FOCC:  return "ff_occ";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] obs(input int s);
    case (s)
      S_RDY:   return {31'd0, rdy};
      S_ID:    return {29'd0, id};
      S_OH:    return {24'd0, oh};
      S_OCC:   return {24'd0, occ};
      S_CNT:   return {28'd0, cnt};
      S_ERR:   return {31'd0, err};
      S_FID:   return {29'd0, id_f};
      S_FOCC:  return {24'd0, occ_f};
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic ex(input int s, input logic [31:0] v);
    exp_t e;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, o, e);
      $error("%s observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(nm(e.sig), obs(e.sig), e.val);
    end
  endtask

  // Free count must always equal W minus the number of occupied slots.
  task automatic inv();
    int pc;
    pc = 0;
    for (int i = 0; i < W; i++) pc += int'(occ[i]);
    check("invariant", {28'd0, cnt}, 32'(W - pc));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    inv();
  endtask

  task automatic drive(input logic av, input logic [1:0] fv, input logic [2:0] f0,
                       input logic [2:0] f1, input logic fl);
    alloc_valid_i = av;
    free_valid_i  = fv;
    free_id_i     = {f1, f0};
    flush_i       = fl;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic ex_reset();
    ex(S_RDY, 32'd1); ex(S_ID, 32'd0); ex(S_OH, 32'h01);
    ex(S_OCC, 32'h00); ex(S_CNT, 32'd8); ex(S_ERR, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    #12;
    rst_i = 1'b0;
    ex_reset();
    drain();

    // Fill in order 0..7.
    for (int i = 0; i < W; i++) begin
      drive(1'b1, 2'b00, 3'd0, 3'd0, 1'b0);
      ex(S_ID, 32'(i));
      drain();
      tick();
    end
    idle();
    ex(S_RDY, 32'd0); ex(S_CNT, 32'd0); ex(S_OCC, 32'hff); ex(S_ERR, 32'd0); ex(S_OH, 32'h00);
    drain();

    // Free slot 3 from full, then reallocate it.
    drive(1'b0, 2'b01, 3'd3, 3'd0, 1'b0);
    tick(); idle();
    ex(S_RDY, 32'd1); ex(S_ID, 32'd3); ex(S_CNT, 32'd1); ex(S_OH, 32'h08);
    drain();
    drive(1'b1, 2'b00, 3'd0, 3'd0, 1'b0);
    tick(); idle();
    ex(S_RDY, 32'd0); ex(S_OCC, 32'hff);
    drain();

    // Free 0..4, leaving ptr at 4.
    drive(1'b0, 2'b11, 3'd0, 3'd1, 1'b0); tick();
    drive(1'b0, 2'b11, 3'd2, 3'd3, 1'b0); tick();
    drive(1'b0, 2'b01, 3'd4, 3'd0, 1'b0); tick();
    idle();
    ex(S_OCC, 32'he0); ex(S_CNT, 32'd5); ex(S_ID, 32'd4);
    drain();

    // Allocate 4 (ptr->5), free 4: search from 5 wraps to 0.
    drive(1'b1, 2'b00, 3'd0, 3'd0, 1'b0); tick();
    drive(1'b0, 2'b01, 3'd4, 3'd0, 1'b0); tick();
    idle();
    ex(S_OCC, 32'he0); ex(S_ID, 32'd0);
    drain();
    drive(1'b1, 2'b00, 3'd0, 3'd0, 1'b0);
    ex(S_ID, 32'd0);
    drain();
    tick(); idle();
    ex(S_OCC, 32'he1); ex(S_ID, 32'd1); ex(S_CNT, 32'd4);
    drain();

    // Build occ=0100_0011 with ptr=2.
    drive(1'b1, 2'b00, 3'd0, 3'd0, 1'b0); tick();
    drive(1'b0, 2'b11, 3'd5, 3'd7, 1'b0); tick();
    idle();
    ex(S_OCC, 32'h43); ex(S_CNT, 32'd5); ex(S_ID, 32'd2);
    drain();

    // Allocate slot 2 while freeing 0 and 6 in the same cycle.
    drive(1'b1, 2'b11, 3'd0, 3'd6, 1'b0);
    ex(S_ID, 32'd2);
    drain();
    tick(); idle();
    ex(S_OCC, 32'h06); ex(S_CNT, 32'd6); ex(S_ERR, 32'd0); ex(S_ID, 32'd3);
    drain();

    // Free of an unoccupied slot sets a sticky error.
    drive(1'b0, 2'b01, 3'd4, 3'd0, 1'b0);
    tick(); idle();
    ex(S_ERR, 32'd1); ex(S_OCC, 32'h06); ex(S_CNT, 32'd6);
    drain();
    tick();
    ex(S_ERR, 32'd1);
    drain();

    // Both ports free slot 1: cleared and counted once.
    drive(1'b0, 2'b11, 3'd1, 3'd1, 1'b0);
    tick(); idle();
    ex(S_OCC, 32'h04); ex(S_CNT, 32'd7); ex(S_ERR, 32'd1);
    drain();

    // Flush overrides a concurrent alloc and a bad free.
    drive(1'b1, 2'b01, 3'd5, 3'd0, 1'b1);
    tick(); idle();
    ex(S_ERR, 32'd0); ex(S_OCC, 32'h00); ex(S_CNT, 32'd8); ex(S_ID, 32'd0); ex(S_RDY, 32'd1);
    drain();

    // Next-fit vs first-fit: occ=0000_0001, ptr=5.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b00, 3'd0, 3'd0, 1'b0);
      tick();
    end
    drive(1'b0, 2'b11, 3'd1, 3'd2, 1'b0); tick();
    drive(1'b0, 2'b11, 3'd3, 3'd4, 1'b0); tick();
    idle();
    ex(S_OCC, 32'h01); ex(S_ID, 32'd5); ex(S_FOCC, 32'h01); ex(S_FID, 32'd1);
    drain();

    // Async reset in the middle of a handshake cycle.
    drive(1'b1, 2'b00, 3'd0, 3'd0, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    ex_reset();
    ex(S_FID, 32'd0); ex(S_FOCC, 32'h00);
    drain();
    #3;
    rst_i = 1'b0;
    idle();
    tick();
    ex(S_OCC, 32'h00); ex(S_CNT, 32'd8);
    drain();

    // Requesting while full is an error and changes nothing else.
    for (int i = 0; i < W; i++) begin
      drive(1'b1, 2'b00, 3'd0, 3'd0, 1'b0);
      tick();
    end
    ex(S_ERR, 32'd0); ex(S_RDY, 32'd0);
    drain();
    tick(); idle();
    ex(S_ERR, 32'd1); ex(S_OCC, 32'hff); ex(S_CNT, 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
